fir_sample_feeder: RTL and testbench
====================================

# fir_sample_feeder

Upstream rate adapter for the multicycle FIR datapath. It accepts Q(WI).(WF) input samples from a valid/ready producer and buffers them in a small FIFO. It then presents exactly one sample to the FIR every TAPSIZE clock cycles, holding `x` stable for the whole tap sweep. A one-cycle `x_load` strobe marks each new sample. If the FIFO is empty when a sample is due, the block inserts a zero sample so the filter time base never slips, and the event is flagged.

## Interface
Parameters:
- TAPSIZE, 3, cycles per FIR sample (tap sweep length); ≥ 2
- WI, 1, integer bits of sample
- WF, 15, fraction bits of sample
- DEPTH, 4, FIFO depth in samples; power of two, ≥ 2

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RST  input  1  reset, asynchronous, active-high
- in_data  input  WI+WF  signed producer sample
- in_valid  input  1  producer has sample
- in_ready  output  1  FIFO can accept; equals !full
- enable  input  1  run/freeze control for the sample schedule
- clr_underflow  input  1  synchronous clear of `underflow`
- x  output  WI+WF  signed sample to FIR, registered
- x_load  output  1  one-cycle pulse, high in the first cycle a new `x` is presented
- underflow  output  1  sticky: a zero sample was inserted
- fill  output  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- Push: an edge with in_valid && in_ready writes in_data and fill +1. in_ready is derived from fill before any same-cycle pop, so a full FIFO refuses the push even when a pop happens in the same cycle.
- No bypass: a sample written on edge N is poppable from edge N+1 onward.
- States: IDLE, RUN.
- IDLE:
  - Entered on reset.
  - Leaves to RUN at the first edge with enable && fill≠0.
  - On that edge: pop head into `x`, x_load ← 1, slot ← 0.
- RUN, slot counter 0..TAPSIZE-1:
  - enable=1: slot advances each edge.
  - At the edge where slot==TAPSIZE-1: slot wraps to 0 and a new sample is issued.
  - Issued sample is the FIFO head if fill≠0. Otherwise it is zero, underflow ← 1, and no pop occurs.
  - x_load is high only in the cycle after an issue edge.
- enable=0 in RUN: slot, `x` and FIFO read side frozen, x_load=0; pushes still accepted. The schedule resumes from the frozen slot.
- RUN never returns to IDLE except via reset.
- underflow: set by zero insertion, cleared by clr_underflow. If both happen on the same edge, set wins.
- Simultaneous push and pop on a non-full FIFO: fill unchanged; ordering preserved.
- Arithmetic: samples pass through bit-exact; no scaling or saturation. The zero sample is all bits 0.

## Timing
- Reset values:
  - x=0, x_load=0, underflow=0, fill=0, in_ready=1
  - state IDLE, slot=0, FIFO pointers 0
- Latency: sample accepted on edge N reaches `x` on edge N+1 at the earliest (FIFO empty, IDLE, enable=1); x_load is high in cycle N+1..N+2.
- Steady state: issue edges are spaced exactly TAPSIZE cycles apart while enable=1.
- Reset asserted mid-operation: all state returns to reset values immediately. FIFO contents are discarded (pointers zeroed) and any in-flight push is lost.
- Throughput: the producer may push every cycle until full; sustained drain is 1 sample per TAPSIZE cycles.

## Structure
- Shared package `fir_pkg`: sample width localparam (WI+WF), state encodings (IDLE, RUN), slot-counter width helper. The FIR and this block both import it.
- One sub-module: `sample_fifo`.
  - Synchronous write, registered head read.
  - DEPTH entries, occupancy counter, full/empty flags.
  - Same CLK/RST convention.
- The top level holds the state machine, slot counter, `x`/x_load registers and the underflow flag.

## Test plan
- Reset values: assert RST mid-run with fill=2 → all outputs at reset values in the same cycle (x=0, fill=0, in_ready=1, underflow=0); after release, state IDLE.
- Basic cadence: TAPSIZE=3, enable=1, push 0x1000, 0x2000, 0x3000 on edges 0,1,2 → `x` takes these values on edges 1, 4, 7; x_load high only after those edges; fill peaks at 2.
- Underflow: push one sample 0x4000, then nothing → `x`=0x4000 on edge 1, then `x`=0 on edge 4, underflow=1; clr_underflow on edge 6 → underflow=0 unless another insertion occurs on that same edge (set wins).
- Full/backpressure: DEPTH=4, hold in_valid with values 1..6 from reset with enable=0 → in_ready drops after 4 accepts. Then enable=1 → issues 1,2,3,4 in order, and values 5 and 6 are accepted only as slots free.
- Freeze: enable=0 for 5 cycles at slot=1 → `x` held, no x_load, fill may grow; on re-enable the next issue occurs 2 cycles later.
- Simultaneous push/pop at fill=2 on an issue edge → fill stays 2; output order matches input order.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the multicycle FIR datapath and its sample feeder.
// Holds the default sample format, feeder state encoding and a counter-width helper.
package fir_pkg;

    localparam int FIR_WI   = 1;
    localparam int FIR_WF   = 15;
    localparam int SAMPLE_W = FIR_WI + FIR_WF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } feed_state_t;

    // Width of a counter that runs 0..taps-1; never narrower than one bit.
    function automatic int slot_w(input int taps);
        return (taps > 2) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small sample FIFO: synchronous write, head presented from the storage registers.
// Occupancy counter drives the full/empty flags; a write into a full FIFO is refused.
module sample_fifo
    import fir_pkg::*;
#(
    parameter int W     = SAMPLE_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_en,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_en,
    output logic [W-1:0]     rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_fire;
    logic             rd_fire;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; only the pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({wr_fire, rd_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_sample_feeder.sv
// Rate adapter: buffers producer samples and issues one to the FIR every TAPSIZE cycles,
// inserting a zero sample (and flagging underflow) when the buffer runs dry.
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter int TAPSIZE = 3,
    parameter int WI      = FIR_WI,
    parameter int WF      = FIR_WF,
    parameter int DEPTH   = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [WI+WF-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         enable,
    input  logic                         clr_underflow,
    output logic [WI+WF-1:0]             x,
    output logic                         x_load,
    output logic                         underflow,
    output logic [$clog2(DEPTH+1)-1:0]   fill
);

    localparam int SW     = WI + WF;
    localparam int SLOT_W = slot_w(TAPSIZE);

    feed_state_t       state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [SW-1:0]     x_q;
    logic              x_load_q;
    logic              underflow_q;

    logic              issue;
    logic              pop;
    logic [SW-1:0]     head;
    logic              full;
    logic              empty;

    sample_fifo #(
        .W     (SW),
        .DEPTH (DEPTH),
        .CNT_W ($clog2(DEPTH + 1))
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fill)
    );

    assign in_ready  = !full;
    assign x         = x_q;
    assign x_load    = x_load_q;
    assign underflow = underflow_q;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        issue   = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && !empty) begin
                    state_d = ST_RUN;
                    slot_d  = '0;
                    issue   = 1'b1;
                    pop     = 1'b1;
                end
            end
            ST_RUN: begin
                if (enable) begin
                    if (slot_q == SLOT_W'(TAPSIZE - 1)) begin
                        slot_d = '0;
                        issue  = 1'b1;
                        pop    = !empty;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            x_q         <= '0;
            x_load_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            x_load_q <= issue;
            if (issue) begin
                x_q <= pop ? head : '0;
            end
            // Zero insertion outranks a same-edge clear.
            if (issue && !pop) begin
                underflow_q <= 1'b1;
            end else if (clr_underflow) begin
                underflow_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed self-checking bench for fir_sample_feeder (TAPSIZE=3, DEPTH=4, Q1.15).
module tb_fir_sample_feeder;

    localparam int TAPSIZE = 3;
    localparam int DEPTH   = 4;
    localparam int SW      = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic [SW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          enable;
    logic          clr_underflow;
    logic [SW-1:0] x;
    logic          x_load;
    logic          underflow;
    logic [2:0]    fill;

    int checks = 0;
    int errors = 0;

    fir_sample_feeder #(
        .TAPSIZE (TAPSIZE),
        .WI      (1),
        .WF      (15),
        .DEPTH   (DEPTH)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .enable        (enable),
        .clr_underflow (clr_underflow),
        .x             (x),
        .x_load        (x_load),
        .underflow     (underflow),
        .fill          (fill)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        in_valid      = 1'b0;
        in_data       = '0;
        enable        = 1'b0;
        clr_underflow = 1'b0;
        RST           = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] exp_x;
    bit            accept;
    int            last_load;
    int            n_issued;

    initial begin
        // Reset values
        do_reset();
        check("rst_x", x, 0);
        check("rst_x_load", x_load, 0);
        check("rst_underflow", underflow, 0);
        check("rst_fill", fill, 0);
        check("rst_in_ready", in_ready, 1);

        // Basic cadence: pushes on edges 0,1,2 issue on edges 1,4,7
        do_reset();
        enable = 1'b1; in_valid = 1'b1; in_data = 16'h1000;
        tick();                                             // e0
        check("cad_e0_fill", fill, 1);
        check("cad_e0_xload", x_load, 0);
        in_data = 16'h2000;
        tick();                                             // e1
        check("cad_e1_x", x, 16'h1000);
        check("cad_e1_xload", x_load, 1);
        check("cad_e1_fill", fill, 1);
        in_data = 16'h3000;
        tick();                                             // e2
        check("cad_e2_xload", x_load, 0);
        check("cad_e2_fill", fill, 2);
        in_valid = 1'b0;
        tick();                                             // e3
        check("cad_e3_xload", x_load, 0);
        tick();                                             // e4
        check("cad_e4_x", x, 16'h2000);
        check("cad_e4_xload", x_load, 1);
        check("cad_e4_fill", fill, 1);
        tick(); tick();                                     // e6
        check("cad_e6_x_hold", x, 16'h2000);
        check("cad_e6_xload", x_load, 0);
        tick();                                             // e7
        check("cad_e7_x", x, 16'h3000);
        check("cad_e7_xload", x_load, 1);
        check("cad_e7_fill", fill, 0);
        check("cad_e7_underflow", underflow, 0);

        // Underflow, clear, and set-wins-over-clear
        do_reset();
        enable = 1'b1; in_valid = 1'b1; in_data = 16'h4000;
        tick();                                             // e0
        in_valid = 1'b0;
        tick();                                             // e1
        check("uf_e1_x", x, 16'h4000);
        check("uf_e1_flag", underflow, 0);
        tick(); tick(); tick();                             // e4
        check("uf_e4_x", x, 0);
        check("uf_e4_xload", x_load, 1);
        check("uf_e4_flag", underflow, 1);
        tick();                                             // e5
        check("uf_e5_flag", underflow, 1);
        clr_underflow = 1'b1;
        tick();                                             // e6
        check("uf_e6_cleared", underflow, 0);
        clr_underflow = 1'b0;
        tick();                                             // e7
        check("uf_e7_reset_again", underflow, 1);
        clr_underflow = 1'b1;
        tick(); tick();                                     // e9
        check("uf_e9_cleared", underflow, 0);
        tick();                                             // e10
        check("uf_e10_set_wins", underflow, 1);
        clr_underflow = 1'b0;

        // Full / backpressure: values 1..6 offered with enable low
        do_reset();
        in_valid = 1'b1; in_data = 16'd1;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            accept = in_valid && in_ready;
            tick();
            if (accept) begin
                exp_q.push_back(in_data);
                in_data = in_data + 16'd1;
            end
        end
        check("bp_fill_full", fill, 4);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_accepted", exp_q.size(), 4);
        check("bp_no_issue", x_load, 0);
        enable    = 1'b1;
        last_load = -1;
        n_issued  = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            accept = in_valid && in_ready;
            tick();
            if (x_load) begin
                exp_x = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                check("bp_x_order", x, exp_x);
                if (last_load >= 0) check("bp_spacing", cyc - last_load, TAPSIZE);
                last_load = cyc;
                n_issued++;
            end
            if (accept) begin
                exp_q.push_back(in_data);
                in_data = in_data + 16'd1;
                if (in_data == 16'd7) in_valid = 1'b0;
            end
            if (fill > 3'd4) check("bp_fill_bound", fill, 4);
        end
        check("bp_all_pushed", in_valid, 0);
        check("bp_issue_count", n_issued, 7);
        check("bp_underflow_end", underflow, 1);

        // Freeze at slot 1 for 5 cycles
        do_reset();
        enable = 1'b1; in_valid = 1'b1; in_data = 16'h0111;
        tick();                                             // e0
        in_data = 16'h0222;
        tick();                                             // e1 issue 0111
        check("frz_e1_x", x, 16'h0111);
        in_valid = 1'b0;
        tick();                                             // e2 slot=1
        enable = 1'b0; in_valid = 1'b1; in_data = 16'h0333;
        for (int i = 0; i < 5; i++) begin
            tick();                                         // e3..e7
            in_valid = 1'b0;
            check("frz_xload_low", x_load, 0);
            check("frz_x_held", x, 16'h0111);
        end
        check("frz_fill_grew", fill, 2);
        enable = 1'b1;
        tick();                                             // e8
        check("frz_e8_no_issue", x_load, 0);
        tick();                                             // e9
        check("frz_e9_x", x, 16'h0222);
        check("frz_e9_xload", x_load, 1);
        tick(); tick(); tick();                             // e12
        check("frz_e12_x", x, 16'h0333);

        // Simultaneous push/pop at fill=2, then mid-run reset
        do_reset();
        enable = 1'b1; in_valid = 1'b1; in_data = 16'hA001;
        tick();                                             // e0
        in_data = 16'hA002;
        tick();                                             // e1 issue A001
        in_data = 16'hA003;
        tick();                                             // e2 fill=2
        in_valid = 1'b0;
        check("sp_e2_fill", fill, 2);
        tick();                                             // e3
        in_valid = 1'b1; in_data = 16'hA004;
        tick();                                             // e4 push + pop
        in_valid = 1'b0;
        check("sp_e4_fill", fill, 2);
        check("sp_e4_x", x, 16'hA002);
        tick(); tick(); tick();                             // e7
        check("sp_e7_x", x, 16'hA003);
        check("sp_e7_fill", fill, 1);
        in_valid = 1'b1; in_data = 16'hA005;
        tick();                                             // e8 fill=2
        in_valid = 1'b0;
        check("mr_pre_fill", fill, 2);
        #2 RST = 1'b1;
        #1;
        check("mr_x", x, 0);
        check("mr_fill", fill, 0);
        check("mr_in_ready", in_ready, 1);
        check("mr_underflow", underflow, 0);
        check("mr_xload", x_load, 0);
        tick();
        RST = 1'b0;
        // Back in IDLE: no zero insertion while the FIFO stays empty
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mr_idle_xload", x_load, 0);
            check("mr_idle_underflow", underflow, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
